// File: rtl/ring_phase_monitor_if.sv
// Bundle between a ring_counter count bus and ring_phase_monitor.
// The master side drives the ring and clear_err. The slave side is the monitor.
interface ring_phase_monitor_if #(
  parameter int N  = 4,
  parameter int CW = 16
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  ring;
  logic          clear_err;
  logic          locked;
  logic [PW-1:0] phase;
  logic          rev_tick;
  logic [CW-1:0] rev_count;
  logic          err_onehot;
  logic          err_skip;
  logic [7:0]    err_count;

  modport master (
    output ring, clear_err,
    input  locked, phase, rev_tick, rev_count, err_onehot, err_skip, err_count
  );

  modport slave (
    input  ring, clear_err,
    output locked, phase, rev_tick, rev_count, err_onehot, err_skip, err_count
  );
endinterface

// File: rtl/ring_phase_monitor.sv
// Watches a ring_counter one-hot bus, locks to its rotation, and reports phase and revolutions.
// After lock, a non-one-hot sample or an illegal step latches an error flag.
module ring_phase_monitor #(
  parameter int N          = 4,
  parameter int LOCK_STEPS = 4,
  parameter int CW         = 16,
  parameter int DIR        = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  ring_phase_monitor_if.slave  mon
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = $clog2(LOCK_STEPS + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [N-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      multi = multi | (seen & v[i]);
      seen  = seen | v[i];
    end
    return seen & ~multi;
  endfunction

  function automatic logic [PW-1:0] onehot_index(input logic [N-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = idx | ({PW{v[i]}} & PW'(i));
    end
    return idx;
  endfunction

  function automatic logic [N-1:0] rot_adv(input logic [N-1:0] v);
    if (DIR == 0) begin
      return {v[N-2:0], v[N-1]};
    end else begin
      return {v[0], v[N-1:1]};
    end
  endfunction

  state_t        state_r, state_s;
  logic [N-1:0]  prev_r, prev_s;
  logic          prev_valid_r, prev_valid_s;
  logic [GW-1:0] good_cnt_r, good_cnt_s;
  logic          locked_r, locked_s;
  logic [PW-1:0] phase_r, phase_s;
  logic          rev_tick_r, rev_tick_s;
  logic [CW-1:0] rev_count_r, rev_count_s;
  logic          err_onehot_r, err_onehot_s;
  logic          err_skip_r, err_skip_s;
  logic [7:0]    err_count_r, err_count_s;

  logic          onehot_s;
  logic          hold_s;
  logic          adv_s;
  logic [PW-1:0] ring_idx_s;
  logic [7:0]    err_count_inc_s;

  assign onehot_s        = is_onehot(mon.ring);
  assign hold_s          = prev_valid_r & (mon.ring == prev_r);
  assign adv_s           = prev_valid_r & onehot_s & (mon.ring == rot_adv(prev_r));
  assign ring_idx_s      = onehot_index(mon.ring);
  assign err_count_inc_s = (err_count_r == 8'hFF) ? 8'hFF : (err_count_r + 8'd1);

  // Next-state and next-output logic for the SEARCH/LOCKED/FAULT machine.
  always_comb begin
    state_s      = state_r;
    prev_s       = prev_r;
    prev_valid_s = prev_valid_r;
    good_cnt_s   = good_cnt_r;
    phase_s      = phase_r;
    rev_tick_s   = 1'b0;
    rev_count_s  = rev_count_r;
    err_onehot_s = err_onehot_r;
    err_skip_s   = err_skip_r;
    err_count_s  = err_count_r;

    case (state_r)
      ST_SEARCH: begin
        if (!onehot_s) begin
          good_cnt_s   = '0;
          prev_valid_s = 1'b0;
        end else if (!prev_valid_r) begin
          prev_s       = mon.ring;
          prev_valid_s = 1'b1;
          good_cnt_s   = '0;
        end else if (hold_s) begin
          prev_s = mon.ring;
        end else if (adv_s) begin
          prev_s = mon.ring;
          // Lock entry reports the phase but never counts a revolution.
          if (good_cnt_r == GW'(LOCK_STEPS - 1)) begin
            state_s    = ST_LOCKED;
            good_cnt_s = '0;
            phase_s    = ring_idx_s;
          end else begin
            good_cnt_s = good_cnt_r + GW'(1);
          end
        end else begin
          prev_s     = mon.ring;
          good_cnt_s = '0;
        end
      end
      ST_LOCKED: begin
        if (!onehot_s) begin
          err_onehot_s = 1'b1;
          err_count_s  = err_count_inc_s;
          state_s      = ST_FAULT;
        end else if (hold_s) begin
          state_s = ST_LOCKED;
        end else if (adv_s) begin
          prev_s  = mon.ring;
          phase_s = ring_idx_s;
          if (ring_idx_s == '0) begin
            rev_tick_s  = 1'b1;
            rev_count_s = rev_count_r + CW'(1);
          end else begin
            rev_tick_s = 1'b0;
          end
        end else begin
          err_skip_s  = 1'b1;
          err_count_s = err_count_inc_s;
          state_s     = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (mon.clear_err) begin
          state_s      = ST_SEARCH;
          err_onehot_s = 1'b0;
          err_skip_s   = 1'b0;
          prev_valid_s = 1'b0;
          good_cnt_s   = '0;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s      = ST_SEARCH;
        prev_valid_s = 1'b0;
        good_cnt_s   = '0;
      end
    endcase

    locked_s = (state_s == ST_LOCKED);
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_SEARCH;
      prev_r       <= '0;
      prev_valid_r <= 1'b0;
      good_cnt_r   <= '0;
      locked_r     <= 1'b0;
      phase_r      <= '0;
      rev_tick_r   <= 1'b0;
      rev_count_r  <= '0;
      err_onehot_r <= 1'b0;
      err_skip_r   <= 1'b0;
      err_count_r  <= 8'd0;
    end else begin
      state_r      <= state_s;
      prev_r       <= prev_s;
      prev_valid_r <= prev_valid_s;
      good_cnt_r   <= good_cnt_s;
      locked_r     <= locked_s;
      phase_r      <= phase_s;
      rev_tick_r   <= rev_tick_s;
      rev_count_r  <= rev_count_s;
      err_onehot_r <= err_onehot_s;
      err_skip_r   <= err_skip_s;
      err_count_r  <= err_count_s;
    end
  end

  assign mon.locked     = locked_r;
  assign mon.phase      = phase_r;
  assign mon.rev_tick   = rev_tick_r;
  assign mon.rev_count  = rev_count_r;
  assign mon.err_onehot = err_onehot_r;
  assign mon.err_skip   = err_skip_r;
  assign mon.err_count  = err_count_r;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor (N=4, LOCK_STEPS=4, CW=4, DIR=0).
// It checks the outputs against a model that tracks hot-bit positions with modular arithmetic.
module tb_ring_phase_monitor;
  localparam int N  = 4;
  localparam int LS = 4;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ring_phase_monitor_if #(.N(N), .CW(CW)) bus();

  ring_phase_monitor #(.N(N), .LOCK_STEPS(LS), .CW(CW), .DIR(0)) dut (
    .clock (clock),
    .reset (reset),
    .mon   (bus)
  );

  always #50 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  // model: 0 search, 1 locked, 2 fault; hot positions held as integers
  int m_state = 0, m_pidx = 0, m_good = 0, m_phase = 0, m_rc = 0, m_ec = 0;
  bit m_pv = 0, m_tick = 0, m_eo = 0, m_es = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int hot_index(input logic [N-1:0] v);
    int idx = 0;
    for (int i = 0; i < N; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  always @(posedge clock) begin
    int  idx;
    bit  oh;
    oh  = ($countones(bus.ring) == 1);
    idx = hot_index(bus.ring);
    m_tick = 0;
    if (reset) begin
      m_state = 0; m_pv = 0; m_good = 0; m_phase = 0; m_rc = 0;
      m_eo = 0; m_es = 0; m_ec = 0; m_pidx = 0;
    end else if (m_state == 0) begin
      if (!oh) begin
        m_good = 0; m_pv = 0;
      end else if (!m_pv) begin
        m_pidx = idx; m_pv = 1; m_good = 0;
      end else if (idx == m_pidx) begin
        m_good = m_good;
      end else if (idx == (m_pidx + 1) % N) begin
        m_pidx = idx;
        m_good = m_good + 1;
        if (m_good == LS) begin
          m_state = 1; m_phase = idx; m_good = 0;
        end
      end else begin
        m_pidx = idx; m_good = 0;
      end
    end else if (m_state == 1) begin
      if (!oh) begin
        m_eo = 1; m_ec = (m_ec < 255) ? m_ec + 1 : 255; m_state = 2;
      end else if (idx == m_pidx) begin
        m_pidx = idx;
      end else if (idx == (m_pidx + 1) % N) begin
        m_pidx = idx; m_phase = idx;
        if (idx == 0) begin
          m_tick = 1; m_rc = (m_rc + 1) % (1 << CW);
        end
      end else begin
        m_es = 1; m_ec = (m_ec < 255) ? m_ec + 1 : 255; m_state = 2;
      end
    end else begin
      if (bus.clear_err) begin
        m_state = 0; m_eo = 0; m_es = 0; m_pv = 0; m_good = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("locked", 32'(bus.locked), 32'(m_state == 1));
      chk("rev_tick", 32'(bus.rev_tick), 32'(m_tick));
      chk("rev_count", 32'(bus.rev_count), 32'(m_rc));
      chk("err_onehot", 32'(bus.err_onehot), 32'(m_eo));
      chk("err_skip", 32'(bus.err_skip), 32'(m_es));
      chk("err_count", 32'(bus.err_count), 32'(m_ec));
      if (m_state == 1) chk("phase", 32'(bus.phase), 32'(m_phase));
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic clr, input logic rs);
    @(negedge clock);
    bus.ring      = r;
    bus.clear_err = clr;
    reset         = rs;
    @(posedge clock);
    #1;
  endtask

  task automatic rev_once(input logic clr_mid);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0100, clr_mid, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
  endtask

  initial begin
    bus.ring      = 4'b0001;
    bus.clear_err = 1'b0;

    // reset and idle hold
    cyc(4'b0001, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 1'b1);
    started = 1'b1;
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_phase", 32'(bus.phase), 32'd0);
    chk("rst_rev_count", 32'(bus.rev_count), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    repeat (3) cyc(4'b0001, 1'b0, 1'b0);
    chk("hold_no_lock", 32'(bus.locked), 32'd0);

    // lock, then first revolution
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("pre_lock", 32'(bus.locked), 32'd0);
    cyc(4'b0001, 1'b0, 1'b0);
    chk("lock_edge", 32'(bus.locked), 32'd1);
    chk("lock_no_tick", 32'(bus.rev_tick), 32'd0);
    rev_once(1'b0);
    chk("rev1_tick", 32'(bus.rev_tick), 32'd1);
    chk("rev1_count", 32'(bus.rev_count), 32'd1);
    chk("rev1_phase", 32'(bus.phase), 32'd0);
    chk("model_rev1", 32'(m_rc), 32'd1);
    cyc(4'b0001, 1'b0, 1'b0);
    chk("tick_one_cycle", 32'(bus.rev_tick), 32'd0);

    // hold while locked
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    repeat (3) cyc(4'b0100, 1'b0, 1'b0);
    chk("hold_phase", 32'(bus.phase), 32'd2);
    chk("hold_locked", 32'(bus.locked), 32'd1);

    // non-one-hot fault, clear, relock
    cyc(4'b0110, 1'b0, 1'b0);
    chk("bad_err_onehot", 32'(bus.err_onehot), 32'd1);
    chk("bad_locked", 32'(bus.locked), 32'd0);
    chk("bad_err_count", 32'(bus.err_count), 32'd1);
    cyc(4'b0110, 1'b1, 1'b0);
    chk("clear_flag", 32'(bus.err_onehot), 32'd0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    chk("relock", 32'(bus.locked), 32'd1);
    chk("relock_rev_count", 32'(bus.rev_count), 32'd1);

    // skip fault, ring ignored in FAULT
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("skip_err_skip", 32'(bus.err_skip), 32'd1);
    chk("skip_err_onehot", 32'(bus.err_onehot), 32'd0);
    chk("skip_err_count", 32'(bus.err_count), 32'd2);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    chk("fault_ignored", 32'(bus.locked), 32'd0);
    chk("fault_err_count", 32'(bus.err_count), 32'd2);
    cyc(4'b0001, 1'b1, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    chk("relock2_phase", 32'(bus.phase), 32'd0);
    chk("relock2_locked", 32'(bus.locked), 32'd1);

    // wrap the revolution counter; clear_err pulsed while locked is ignored
    repeat (15) rev_once(1'b0);
    chk("wrap_count", 32'(bus.rev_count), 32'd0);
    chk("wrap_tick", 32'(bus.rev_tick), 32'd1);
    chk("model_wrap", 32'(m_rc), 32'd0);
    rev_once(1'b1);
    chk("post_wrap_count", 32'(bus.rev_count), 32'd1);
    chk("clr_ignored_locked", 32'(bus.locked), 32'd1);

    // reset mid-lock
    cyc(4'b0010, 1'b0, 1'b1);
    chk("mid_rst_locked", 32'(bus.locked), 32'd0);
    chk("mid_rst_phase", 32'(bus.phase), 32'd0);
    chk("mid_rst_count", 32'(bus.rev_count), 32'd0);
    chk("mid_rst_err_count", 32'(bus.err_count), 32'd0);
    chk("mid_rst_flags", 32'({bus.err_onehot, bus.err_skip, bus.rev_tick}), 32'd0);
    cyc(4'b0010, 1'b0, 1'b0);
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
